// File: rtl/shift_matrix.sv
// Scrolling pixel matrix: ROWS x COLS bit image that steps one column per
// cycle in either direction. The incoming column comes from d (feed), from
// the bit shifted out of each row (rotate), or is zero (blank). A step counter
// tracks steps modulo COLS and pulses wrap after the step that returns it to 0.
module shift_matrix #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      dir,
    input  logic [1:0]                mode,
    input  logic [ROWS-1:0]           d,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ROWS*COLS-1:0]      out,
    output logic [$clog2(COLS)-1:0]   step_cnt,
    output logic                      wrap
);

    localparam int unsigned CntW = $clog2(COLS);
    localparam logic [CntW-1:0] CntMax = CntW'(COLS - 1);

    localparam logic [1:0] ModeFeed   = 2'b00;
    localparam logic [1:0] ModeRotate = 2'b01;
    localparam logic [1:0] ModeBlank  = 2'b10;
    localparam logic [1:0] ModeHold   = 2'b11;

    // Row r occupies bits [r*COLS +: COLS] of out, column c at bit c.
    logic [ROWS-1:0][COLS-1:0] pix_q, pix_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      wrap_q, wrap_d;
    logic [ROWS-1:0]           in_bit;
    logic                      step;

    assign in_ready = en && (mode == ModeFeed) && !clr && rst_n;
    assign out      = pix_q;
    assign step_cnt = cnt_q;
    assign wrap     = wrap_q;

    // Decide whether this cycle advances the image by one column.
    always_comb begin
        step = 1'b0;
        if (en && !clr) begin
            unique case (mode)
                ModeFeed:   step = in_valid;
                ModeRotate: step = 1'b1;
                ModeBlank:  step = 1'b1;
                ModeHold:   step = 1'b0;
                default:    step = 1'b0;
            endcase
        end
    end

    // Select the bit entering each row; rotate reuses the bit falling off the far end.
    always_comb begin
        in_bit = '0;
        for (int r = 0; r < ROWS; r++) begin
            unique case (mode)
                ModeFeed:   in_bit[r] = d[r];
                ModeRotate: in_bit[r] = dir ? pix_q[r][0] : pix_q[r][COLS-1];
                default:    in_bit[r] = 1'b0;
            endcase
        end
    end

    // Next image, counter and wrap pulse; clear wins over any step.
    always_comb begin
        pix_d  = pix_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            pix_d = '0;
            cnt_d = '0;
        end else if (step) begin
            for (int r = 0; r < ROWS; r++) begin
                if (dir) begin
                    pix_d[r] = {in_bit[r], pix_q[r][COLS-1:1]};
                end else begin
                    pix_d[r] = {pix_q[r][COLS-2:0], in_bit[r]};
                end
            end
            if (cnt_q == CntMax) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pix_q  <= pix_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_shift_matrix.sv
// Bench for shift_matrix: a 8x32 and a 8x12 instance share one stimulus stream
// and are compared every cycle against an arithmetic model of the image.
module tb_shift_matrix;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, en, dir, in_valid;
    logic [1:0] mode;
    logic [7:0] d;

    logic         in_ready_a, wrap_a;
    logic [255:0] out_a;
    logic [4:0]   cnt_a;
    logic         in_ready_b, wrap_b;
    logic [95:0]  out_b;
    logic [3:0]   cnt_b;

    shift_matrix #(.ROWS(8), .COLS(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir), .mode(mode), .d(d),
        .in_valid(in_valid), .in_ready(in_ready_a), .out(out_a), .step_cnt(cnt_a),
        .wrap(wrap_a)
    );

    shift_matrix #(.ROWS(8), .COLS(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir), .mode(mode), .d(d),
        .in_valid(in_valid), .in_ready(in_ready_b), .out(out_b), .step_cnt(cnt_b),
        .wrap(wrap_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: index 0 is the 32-column instance, index 1 the 12-column one.
    logic [31:0] m_row [2][8];
    int          m_cnt [2];
    logic        m_wrap[2];
    int          m_cols[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) m_row[k][r] = '0;
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
        end
    endtask

    // One rising edge of the reference: rows are integers shifted with << / >>.
    task automatic model_edge();
        logic        stepping;
        logic [31:0] row, mask;
        logic        drop, nb;
        int          cols;
        stepping = en && !clr && ((mode == 2'd0 && in_valid) || mode == 2'd1 || mode == 2'd2);
        for (int k = 0; k < 2; k++) begin
            cols = m_cols[k];
            mask = (cols == 32) ? 32'hFFFF_FFFF : ((32'h1 << cols) - 32'h1);
            if (!rst_n || clr) begin
                for (int r = 0; r < 8; r++) m_row[k][r] = '0;
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
            end else if (stepping) begin
                for (int r = 0; r < 8; r++) begin
                    row  = m_row[k][r];
                    drop = dir ? row[0] : row[cols-1];
                    nb   = (mode == 2'd0) ? d[r] : (mode == 2'd1) ? drop : 1'b0;
                    if (!dir) row = ((row << 1) | 32'(nb)) & mask;
                    else      row = (row >> 1) | (32'(nb) << (cols - 1));
                    m_row[k][r] = row;
                end
                m_cnt[k]  = (m_cnt[k] + 1) % cols;
                m_wrap[k] = (m_cnt[k] == 0);
            end else begin
                m_wrap[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [255:0] exp_img(input int k);
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < m_cols[k]; c++)
                v[r*m_cols[k]+c] = m_row[k][r][c];
        return v;
    endfunction

    // Run one clock with the inputs currently driven, then compare against the model.
    task automatic cycle();
        logic rdy;
        rdy = rst_n && en && (mode == 2'd0) && !clr;
        #1;
        check("in_ready_a", 256'(in_ready_a), 256'(rdy));
        check("in_ready_b", 256'(in_ready_b), 256'(rdy));
        @(posedge clk);
        model_edge();
        #1;
        check("out_a",  256'(out_a),  exp_img(0));
        check("cnt_a",  256'(cnt_a),  256'(m_cnt[0]));
        check("wrap_a", 256'(wrap_a), 256'(m_wrap[0]));
        check("out_b",  256'(out_b),  exp_img(1));
        check("cnt_b",  256'(cnt_b),  256'(m_cnt[1]));
        check("wrap_b", 256'(wrap_b), 256'(m_wrap[1]));
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic dr,
                         input logic v, input logic [7:0] dd);
        en = e; mode = m; dir = dr; in_valid = v; d = dd;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        drive(1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
        cycle();
        clr = 1'b0;
    endtask

    logic [255:0] img;
    int           wraps;

    initial begin
        m_cols[0] = 32;
        m_cols[1] = 12;
        model_reset();
        rst_n = 1'b0; clr = 1'b0;
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'hFF);
        @(posedge clk);
        #1;
        cycle();
        check("rst_out",  256'(out_a),  256'(0));
        check("rst_cnt",  256'(cnt_a),  256'(0));
        check("rst_wrap", 256'(wrap_a), 256'(0));

        // Single feed of 8'h81.
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'h81);
        cycle();
        img = '0; img[0] = 1'b1; img[7*32] = 1'b1;
        check("feed_out", out_a, img);
        check("feed_cnt", 256'(cnt_a), 256'(1));

        // Handshake: in_valid low holds, then exactly one column accepted.
        drive(1'b1, 2'd0, 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 5; i++) cycle();
        check("hold_out", out_a, img);
        check("hold_cnt", 256'(cnt_a), 256'(1));
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'h3C);
        cycle();
        drive(1'b0, 2'd0, 1'b0, 1'b1, 8'h3C);
        cycle();
        check("hs_cnt", 256'(cnt_a), 256'(2));

        // Clear beats a simultaneous feed.
        clr = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'hFF);
        cycle();
        clr = 1'b0;
        check("clr_out", out_a, 256'(0));
        check("clr_cnt", 256'(cnt_a), 256'(0));

        // Rotate: load row 0 = 1, rotate toward lower index.
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'h01);
        cycle();
        check("rot_load", 256'(out_a[31:0]), 256'(32'h0000_0001));
        drive(1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
        cycle();
        check("rot_1", 256'(out_a[31:0]), 256'(32'h8000_0000));
        wraps = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (wrap_a) wraps++;
        end
        check("rot_32", 256'(out_a[31:0]), 256'(32'h8000_0000));
        check("rot_wraps", 256'(wraps), 256'(1));

        // Blank/wrap on the 12-column instance.
        do_clear();
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'hFF);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (wrap_b) wraps++;
        end
        check("fill_b", 256'(out_b), 256'({96{1'b1}}));
        check("fill_wraps", 256'(wraps), 256'(1));
        drive(1'b1, 2'd2, 1'b0, 1'b1, 8'hFF);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (wrap_b) wraps++;
        end
        check("blank_b", 256'(out_b), 256'(0));
        check("blank_cnt", 256'(cnt_b), 256'(0));
        check("blank_wraps", 256'(wraps), 256'(1));

        // Reset mid-scroll at step_cnt 17.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd0, 1'(i % 2), 1'b1, 8'($urandom));
            cycle();
        end
        check("pre_rst_cnt", 256'(cnt_a), 256'(17));
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 1'b0, 1'b1, 8'hA5);
        cycle();
        check("mid_rst_out",  out_a, 256'(0));
        check("mid_rst_cnt",  256'(cnt_a), 256'(0));
        check("mid_rst_wrap", 256'(wrap_a), 256'(0));
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 3; i++) cycle();
        check("hold_mode_out", out_a, 256'(0));
        check("hold_mode_cnt", 256'(cnt_a), 256'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), 8'($urandom));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
